// File: rtl/display_scan_if.sv
// Host-side bundle for the display scan controller: value updates in,
// decoder/digit drive and frame status out.
interface display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic                    enable;
    logic                    blank_lz;
    logic [3:0]              digit_num;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    blank;
    logic                    pending;
    logic                    frame;

    modport master (
        output value, load, enable, blank_lz,
        input  digit_num, digit_en, blank, pending, frame
    );

    modport slave (
        input  value, load, enable, blank_lz,
        output digit_num, digit_en, blank, pending, frame
    );
endinterface

// File: rtl/display_scan.sv
// Multiplexed seven-segment scan controller with frame-aligned value
// updates, leading-zero blanking and an inter-digit guard interval.
module display_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 50000,
    parameter int GUARD      = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    display_scan_if.slave bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(DWELL);
    localparam int NS = 2 ** IW;
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_GRD = CW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DW-1:0] disp_reg;
    logic [DW-1:0] pend_reg;
    logic          pend_flag;
    logic          en_q;

    logic          slot_end;
    logic          boundary;
    logic [NS-1:0] zero_from;
    logic          lz;
    logic          on;

    assign slot_end = (cnt == CNT_MAX);
    assign boundary = en_q && slot_end && (idx == IDX_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            idx       <= '0;
            disp_reg  <= '0;
            pend_reg  <= '0;
            pend_flag <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            en_q <= bus.enable;
            if (en_q) begin
                if (slot_end) begin
                    cnt <= '0;
                    idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            // A load landing on the boundary bypasses the pending stage.
            if (bus.load && boundary) begin
                disp_reg  <= bus.value;
                pend_reg  <= bus.value;
                pend_flag <= 1'b0;
            end else begin
                if (boundary && pend_flag) begin
                    disp_reg  <= pend_reg;
                    pend_flag <= 1'b0;
                end
                if (bus.load) begin
                    pend_reg  <= bus.value;
                    pend_flag <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        zero_from = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zero_from[i] = ((disp_reg >> (4 * i)) == '0);
        end
    end

    assign lz = bus.blank_lz && (idx != '0) && zero_from[idx];
    assign on = en_q && (cnt >= CNT_GRD) && !lz;

    assign bus.digit_num = disp_reg[4*idx +: 4];
    assign bus.digit_en  = on ? (NUM_DIGITS'(1) << idx) : '0;
    assign bus.blank     = !on;
    assign bus.pending   = pend_flag;
    assign bus.frame     = boundary;
endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: directed scenarios plus a
// randomized run against a time-position reference model.
module tb_display_scan;
    localparam int ND = 4;
    localparam int DW = 4;
    localparam int GD = 1;
    localparam int FR = ND * DW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    display_scan_if #(.NUM_DIGITS(ND)) ifa ();
    display_scan_if #(.NUM_DIGITS(1))  ifb ();

    display_scan #(.NUM_DIGITS(ND), .DWELL(DW), .GUARD(GD)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa)
    );
    display_scan #(.NUM_DIGITS(1), .DWELL(DW), .GUARD(GD)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: scan position is the count of enabled cycles since reset.
    int          t_a, t_b;
    bit          enq_a, enq_b, pf_a, pf_b;
    logic [15:0] shown_a, pv_a;
    logic [3:0]  shown_b, pv_b;

    task automatic model_reset();
        t_a = 0; enq_a = 0; pf_a = 0; shown_a = '0; pv_a = '0;
        t_b = 0; enq_b = 0; pf_b = 0; shown_b = '0; pv_b = '0;
    endtask

    task automatic tick();
        bit bnd;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            bnd = enq_a && (t_a % FR) == FR - 1;
            if (ifa.load && bnd) begin
                shown_a = ifa.value; pf_a = 0;
            end else begin
                if (bnd && pf_a) begin shown_a = pv_a; pf_a = 0; end
                if (ifa.load) begin pv_a = ifa.value; pf_a = 1; end
            end
            if (enq_a) t_a++;
            enq_a = ifa.enable;
            bnd = enq_b && (t_b % DW) == DW - 1;
            if (ifb.load && bnd) begin
                shown_b = ifb.value; pf_b = 0;
            end else begin
                if (bnd && pf_b) begin shown_b = pv_b; pf_b = 0; end
                if (ifb.load) begin pv_b = ifb.value; pf_b = 1; end
            end
            if (enq_b) t_b++;
            enq_b = ifb.enable;
        end
        #1;
    endtask

    function automatic logic [3:0] exp_en_a();
        int s, c;
        logic [15:0] rest;
        s = (t_a / DW) % ND;
        c = t_a % DW;
        rest = shown_a >> (4 * s);
        if (enq_a && c >= GD && !(ifa.blank_lz && s != 0 && rest == 16'h0))
            return 4'(1 << s);
        return 4'h0;
    endfunction

    function automatic logic [3:0] exp_num_a();
        logic [15:0] rest;
        rest = shown_a >> (4 * ((t_a / DW) % ND));
        return rest[3:0];
    endfunction

    function automatic logic exp_frame_a();
        return enq_a && (t_a % FR) == FR - 1;
    endfunction

    task automatic go_frame_end();
        for (int i = 0; i < 40; i++) begin
            if (exp_frame_a()) break;
            tick();
        end
    endtask

    task automatic test_reset();
        if (ifa.digit_en !== 4'h0 || ifa.blank !== 1'b1 || ifa.digit_num !== 4'h0
            || ifa.pending !== 1'b0 || ifa.frame !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_init en=%b blank=%b num=%h pend=%b frame=%b need 0000/1/0/0/0",
                     ifa.digit_en, ifa.blank, ifa.digit_num, ifa.pending, ifa.frame);
        end
        n_cmp++;
        reset_n = 1'b1;
        ifa.value = 16'h9876; ifa.load = 1'b1; ifa.enable = 1'b1;
        tick();
        ifa.load = 1'b0;
        repeat (6) tick();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        if (ifa.digit_en !== 4'h0 || ifa.blank !== 1'b1 || ifa.digit_num !== 4'h0
            || ifa.pending !== 1'b0 || ifa.frame !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async en=%b blank=%b num=%h pend=%b frame=%b need 0000/1/0/0/0",
                     ifa.digit_en, ifa.blank, ifa.digit_num, ifa.pending, ifa.frame);
        end
        n_cmp++;
        ifa.enable = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ifa.digit_en !== 4'h0 || ifa.blank !== 1'b1 || ifa.pending !== 1'b0
                || ifa.frame !== 1'b0 || ifa.digit_num !== 4'h0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d en=%b blank=%b pend=%b frame=%b num=%h",
                         i, ifa.digit_en, ifa.blank, ifa.pending, ifa.frame, ifa.digit_num);
            end
            n_cmp++;
        end
    endtask

    task automatic test_basic_scan();
        int cyc;
        logic [3:0] en_e, num_e;
        ifa.value = 16'h1234; ifa.load = 1'b1; ifa.enable = 1'b1;
        tick();
        ifa.load = 1'b0;
        for (cyc = 1; cyc < 40; cyc++) begin
            if (ifa.frame) break;
            if (ifa.pending !== 1'b1) begin
                n_bad++;
                $display("FAIL basic_pending cyc=%0d got %b need 1", cyc, ifa.pending);
            end
            n_cmp++;
            tick();
        end
        if (cyc !== 16) begin
            n_bad++;
            $display("FAIL basic_frame_cycle got %0d need 16", cyc);
        end
        n_cmp++;
        tick();
        if (ifa.pending !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_pending_clear got %b need 0", ifa.pending);
        end
        n_cmp++;
        for (int k = 0; k < FR; k++) begin
            en_e  = (k % DW == 0) ? 4'h0 : 4'(1 << (k / DW));
            num_e = 4'(4 - k / DW);
            if (ifa.digit_en !== en_e || ifa.digit_num !== num_e
                || ifa.blank !== (en_e == 4'h0)) begin
                n_bad++;
                $display("FAIL basic_slot k=%0d en=%b num=%h blank=%b need en=%b num=%h",
                         k, ifa.digit_en, ifa.digit_num, ifa.blank, en_e, num_e);
            end
            n_cmp++;
            tick();
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [3] = '{16'h0050, 16'h0000, 16'h0050};
        logic        blzs [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0]  lits [3] = '{4'b0011, 4'b0001, 4'b1111};
        logic [3:0]  en_e, num_e;
        logic [15:0] rest;
        for (int e = 0; e < 3; e++) begin
            ifa.blank_lz = blzs[e];
            ifa.value = vals[e]; ifa.load = 1'b1;
            tick();
            ifa.load = 1'b0;
            go_frame_end();
            tick();
            for (int k = 0; k < FR; k++) begin
                rest  = vals[e] >> (4 * (k / DW));
                num_e = rest[3:0];
                en_e  = (k % DW >= GD && lits[e][k / DW]) ? 4'(1 << (k / DW)) : 4'h0;
                if (ifa.digit_en !== en_e || ifa.digit_num !== num_e
                    || ifa.blank !== (en_e == 4'h0)) begin
                    n_bad++;
                    $display("FAIL lz e=%0d k=%0d en=%b num=%h blank=%b need en=%b num=%h",
                             e, k, ifa.digit_en, ifa.digit_num, ifa.blank, en_e, num_e);
                end
                n_cmp++;
                tick();
            end
        end
    endtask

    task automatic test_atomic();
        logic [15:0] old_v = 16'h0050;
        logic [15:0] rest;
        ifa.blank_lz = 1'b0;
        repeat (2) tick();
        ifa.value = 16'hAAAA; ifa.load = 1'b1;
        tick();
        ifa.load = 1'b0;
        tick();
        ifa.value = 16'hBBBB; ifa.load = 1'b1;
        tick();
        ifa.load = 1'b0;
        for (int k = 5; k < FR; k++) begin
            rest = old_v >> (4 * (k / DW));
            if (ifa.digit_num !== rest[3:0] || ifa.pending !== 1'b1) begin
                n_bad++;
                $display("FAIL atomic_old k=%0d num=%h pend=%b need num=%h pend=1",
                         k, ifa.digit_num, ifa.pending, rest[3:0]);
            end
            n_cmp++;
            tick();
        end
        for (int k = 0; k < FR; k++) begin
            if (ifa.digit_num !== 4'hB || ifa.pending !== 1'b0) begin
                n_bad++;
                $display("FAIL atomic_new k=%0d num=%h pend=%b need num=b pend=0",
                         k, ifa.digit_num, ifa.pending);
            end
            n_cmp++;
            if (k == FR - 1) begin
                if (ifa.frame !== 1'b1) begin
                    n_bad++;
                    $display("FAIL atomic_frame got %b need 1", ifa.frame);
                end
                n_cmp++;
                ifa.value = 16'hCCCC; ifa.load = 1'b1;
            end
            tick();
        end
        ifa.load = 1'b0;
        for (int k = 0; k < FR; k++) begin
            if (ifa.digit_num !== 4'hC || ifa.pending !== 1'b0) begin
                n_bad++;
                $display("FAIL atomic_direct k=%0d num=%h pend=%b need num=c pend=0",
                         k, ifa.digit_num, ifa.pending);
            end
            n_cmp++;
            tick();
        end
    endtask

    task automatic test_pause();
        int cyc;
        for (int i = 0; i < 20; i++) begin
            if (t_a % FR == 9) break;
            tick();
        end
        ifa.enable = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (ifa.digit_en !== 4'h0 || ifa.blank !== 1'b1 || ifa.frame !== 1'b0) begin
                n_bad++;
                $display("FAIL pause_dark i=%0d en=%b blank=%b frame=%b need 0000/1/0",
                         i, ifa.digit_en, ifa.blank, ifa.frame);
            end
            n_cmp++;
        end
        ifa.enable = 1'b1;
        for (cyc = 10; cyc < 40; ) begin
            tick();
            cyc++;
            if (cyc == 11) begin
                if (ifa.digit_en !== 4'b0100 || ifa.digit_num !== 4'hC) begin
                    n_bad++;
                    $display("FAIL pause_resume en=%b num=%h need 0100/c",
                             ifa.digit_en, ifa.digit_num);
                end
                n_cmp++;
            end
            if (ifa.frame) break;
        end
        if (cyc !== 16) begin
            n_bad++;
            $display("FAIL pause_frame_delay got %0d need 16", cyc);
        end
        n_cmp++;
    endtask

    task automatic test_random();
        logic [15:0] msk;
        for (int i = 0; i < 400; i++) begin
            msk = 16'($urandom);
            ifa.load   = ($urandom % 6 == 0);
            ifa.value  = 16'($urandom) & msk & {msk[7:0], msk[15:8]};
            ifa.enable = ($urandom % 8 != 0);
            if ($urandom % 16 == 0) ifa.blank_lz = ~ifa.blank_lz;
            tick();
            if (ifa.digit_en !== exp_en_a() || ifa.blank !== (exp_en_a() == 4'h0)) begin
                n_bad++;
                $display("FAIL rand_en i=%0d en=%b blank=%b need en=%b",
                         i, ifa.digit_en, ifa.blank, exp_en_a());
            end
            n_cmp++;
            if (ifa.digit_num !== exp_num_a()) begin
                n_bad++;
                $display("FAIL rand_num i=%0d got %h need %h", i, ifa.digit_num, exp_num_a());
            end
            n_cmp++;
            if (ifa.frame !== exp_frame_a() || ifa.pending !== pf_a) begin
                n_bad++;
                $display("FAIL rand_status i=%0d frame=%b pend=%b need %b/%b",
                         i, ifa.frame, ifa.pending, exp_frame_a(), pf_a);
            end
            n_cmp++;
            if ($countones(ifa.digit_en) > 1) begin
                n_bad++;
                $display("FAIL rand_onehot i=%0d en=%b need at most one bit", i, ifa.digit_en);
            end
            n_cmp++;
        end
        ifa.load = 1'b0;
    endtask

    task automatic test_single();
        int frames = 0;
        logic en_e;
        ifb.blank_lz = 1'b1; ifb.value = 4'h0; ifb.load = 1'b1; ifb.enable = 1'b1;
        tick();
        ifb.load = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (k == 9) begin ifb.value = 4'h9; ifb.load = 1'b1; end
            if (k == 10) ifb.load = 1'b0;
            en_e = (k % DW >= GD);
            if (ifb.digit_en !== en_e || ifb.blank !== !en_e) begin
                n_bad++;
                $display("FAIL single_en k=%0d en=%b blank=%b need en=%b",
                         k, ifb.digit_en, ifb.blank, en_e);
            end
            n_cmp++;
            if (ifb.frame !== (k % DW == DW - 1) || ifb.digit_num !== shown_b) begin
                n_bad++;
                $display("FAIL single_frame k=%0d frame=%b num=%h need frame=%b num=%h",
                         k, ifb.frame, ifb.digit_num, (k % DW == DW - 1), shown_b);
            end
            n_cmp++;
            if (ifb.frame) frames++;
            tick();
        end
        if (frames !== 6 || shown_b !== 4'h9 || ifb.digit_num !== 4'h9) begin
            n_bad++;
            $display("FAIL single_count frames=%0d num=%h need 6/9", frames, ifb.digit_num);
        end
        n_cmp++;
    endtask

    initial begin
        ifa.value = '0; ifa.load = 1'b0; ifa.enable = 1'b0; ifa.blank_lz = 1'b0;
        ifb.value = '0; ifb.load = 1'b0; ifb.enable = 1'b0; ifb.blank_lz = 1'b0;
        model_reset();
        repeat (2) tick();
        test_reset();
        test_basic_scan();
        test_lz();
        test_atomic();
        test_pause();
        test_random();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
